// File: rtl/occ_pkg.sv
// occ_pkg: state encodings and constants shared by the occupancy-code DDR read and write paths.
package occ_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN,
        FIN
    } occ_state_e;

    localparam int          OCC_WORD_BYTES       = 8;
    localparam logic [31:0] OCC_DDR_BASE_ADDRESS = 32'h0F00_0000;

endpackage

// File: rtl/occ_word_unpacker.sv
// occ_word_unpacker: serializes the first i_count bytes of a 64-bit word, LSB first, over valid/ready.
module occ_word_unpacker
    import occ_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic [63:0] i_data,
    input  logic [3:0]  i_count,
    input  logic        i_ready,
    output logic [7:0]  o_code,
    output logic        o_valid,
    output logic        o_last
);

    logic [63:0] word;
    logic [2:0]  idx;
    logic [3:0]  cnt;

    assign o_code = word[{idx, 3'b000} +: 8];
    assign o_last = o_valid & ({1'b0, idx} == cnt - 4'd1);

    // a load overrides the final handshake so the next word follows with no bubble
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            word    <= '0;
            idx     <= '0;
            cnt     <= '0;
            o_valid <= 1'b0;
        end else if (i_load) begin
            word    <= i_data;
            idx     <= '0;
            cnt     <= i_count;
            o_valid <= 1'b1;
        end else if (o_valid & i_ready) begin
            if (o_last)
                o_valid <= 1'b0;
            else
                idx <= idx + 3'd1;
        end
    end

endmodule

// File: rtl/occ_code_ddr_reader.sv
// occ_code_ddr_reader: fetches packed 64-bit code words from DDR and replays them as a byte stream.
// OCC_READ_PREFETCH_EN adds a second word buffer so the next read overlaps the current drain.
module occ_code_ddr_reader
    import occ_pkg::*;
#(
    parameter logic [31:0] DDR_BASE_ADDRESS = OCC_DDR_BASE_ADDRESS,
    parameter int          CNT_WIDTH        = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [CNT_WIDTH-1:0] i_n_codes,
    output logic                 o_initreadtxn,
    output logic [31:0]          o_read_address,
    input  logic                 i_read_TxnDone,
    input  logic [63:0]          i_read_data,
    output logic [7:0]           o_code,
    output logic                 o_code_valid,
    input  logic                 i_code_ready,
    output logic                 o_code_last,
    output logic                 o_busy,
    output logic                 o_done
);

    occ_state_e           state, state_nxt;
    logic [CNT_WIDTH-1:0] n_q, left, sent;
    logic                 outstanding, cap, word_end, load_direct, load_pf, u_load, u_last, pf_issue;
    logic [3:0]           cnt_now, u_cnt;
    logic [63:0]          u_data;

    // left counts bytes not yet fetched, so it sizes the word being captured
    assign cap         = i_read_TxnDone & outstanding;
    assign word_end    = o_code_valid & u_last & i_code_ready;
    assign cnt_now     = (left >= CNT_WIDTH'(OCC_WORD_BYTES)) ? 4'(OCC_WORD_BYTES) : left[3:0];
    assign load_direct = cap & ((state == WAIT) | word_end);
    assign u_load      = load_direct | load_pf;
    assign o_code_last = o_code_valid & (sent == n_q - CNT_WIDTH'(1));

`ifdef OCC_READ_PREFETCH_EN
    logic [63:0] pf_data;
    logic [3:0]  pf_cnt;
    logic        pf_full, first_drain;

    assign pf_issue = (state == DRAIN) & first_drain & (left != '0) & ~outstanding;
    assign load_pf  = pf_full & word_end;
    assign u_data   = load_pf ? pf_data : i_read_data;
    assign u_cnt    = load_pf ? pf_cnt : cnt_now;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            pf_data     <= '0;
            pf_cnt      <= '0;
            pf_full     <= 1'b0;
            first_drain <= 1'b0;
        end else begin
            first_drain <= u_load;
            if (cap & ~load_direct) begin
                pf_data <= i_read_data;
                pf_cnt  <= cnt_now;
                pf_full <= 1'b1;
            end else if (load_pf) begin
                pf_full <= 1'b0;
            end
        end
    end
`else
    assign pf_issue = 1'b0;
    assign load_pf  = 1'b0;
    assign u_data   = i_read_data;
    assign u_cnt    = cnt_now;
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = i_start ? ((i_n_codes == '0) ? FIN : REQ) : IDLE;
            REQ:     state_nxt = WAIT;
            WAIT:    state_nxt = cap ? DRAIN : WAIT;
            DRAIN:   state_nxt = !word_end ? DRAIN :
                                 u_load ? DRAIN :
                                 outstanding ? WAIT :
                                 (left != '0) ? REQ : FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_initreadtxn = (state == REQ) | pf_issue;
        o_done        = state == FIN;
        o_busy        = state != IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            n_q            <= '0;
            left           <= '0;
            sent           <= '0;
            o_read_address <= '0;
            outstanding    <= 1'b0;
        end else begin
            if ((state == IDLE) && i_start) begin
                n_q            <= i_n_codes;
                left           <= i_n_codes;
                sent           <= '0;
                o_read_address <= DDR_BASE_ADDRESS;
            end
            if (cap) begin
                left           <= left - CNT_WIDTH'(cnt_now);
                o_read_address <= o_read_address + 32'd8;
            end
            if (o_code_valid & i_code_ready)
                sent <= sent + CNT_WIDTH'(1);
            outstanding <= o_initreadtxn | (outstanding & ~i_read_TxnDone);
        end
    end

    occ_word_unpacker u_unpacker (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (u_load),
        .i_data  (u_data),
        .i_count (u_cnt),
        .i_ready (i_code_ready),
        .o_code  (o_code),
        .o_valid (o_code_valid),
        .o_last  (u_last)
    );

endmodule
